// File: rtl/fb_bank_arbiter.sv
// ---------------------------------------------------------------------------
// fb_bank_arbiter
//
// Owns the single-port frame-buffer RAM (two banks of 2^ADDR_BITS pixels) that
// feeds the LED panel scan. The scan reader has absolute priority on the RAM
// slot; a pixel writer fills the back bank in the remaining slots. A bank swap
// is requested by the writer and taken at the next frame boundary. With
// COPY_ON_SWAP=1 the new front bank is then copied into the back bank, so the
// writer can continue with incremental updates.
//
// Ports:
//   clk, reset             pixel clock, asynchronous active-high reset
//   scan_req/scan_addr     scan read request and pixel address (front bank)
//   scan_data/scan_valid   read data (RAM passthrough), valid 1 cycle after req
//   frame_end              pulse from scanner after the last row is latched
//   wr_valid/wr_ready      writer handshake
//   wr_addr/wr_data        writer pixel address (back bank) and data
//   swap_req/swap_done     swap request pulse / swap (and copy) complete pulse
//   front                  bank currently displayed
//   busy                   swap pending or copy in progress
//   mem_*                  RAM interface; mem_rdata valid 1 cycle after address
// ---------------------------------------------------------------------------
module fb_bank_arbiter #(
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned DATA_BITS    = 24,
    parameter bit          COPY_ON_SWAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_req,
    input  logic [ADDR_BITS-1:0] scan_addr,
    output logic [DATA_BITS-1:0] scan_data,
    output logic                 scan_valid,
    input  logic                 frame_end,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 swap_req,
    output logic                 swap_done,
    output logic                 front,
    output logic                 busy,
    output logic [ADDR_BITS:0]   mem_addr,
    output logic                 mem_we,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam logic [2:0] ST_WRITE     = 3'd0;
    localparam logic [2:0] ST_SWAP_WAIT = 3'd1;
    localparam logic [2:0] ST_COPY_RD   = 3'd2;
    localparam logic [2:0] ST_COPY_CAP  = 3'd3;
    localparam logic [2:0] ST_COPY_WR   = 3'd4;

    localparam logic [ADDR_BITS-1:0] CNT_LAST = '1;

    logic [2:0]           state_q, state_d;
    logic                 front_q, front_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0] copy_buf_q, copy_buf_d;
    logic                 scan_valid_q;
    logic                 swap_done_q, swap_done_d;

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        cnt_d       = cnt_q;
        copy_buf_d  = copy_buf_q;
        swap_done_d = 1'b0;
        wr_ready    = 1'b0;
        // Scan read is the default owner of the RAM slot.
        mem_addr    = {front_q, scan_addr};
        mem_we      = 1'b0;
        mem_wdata   = wr_data;

        case (state_q)
            ST_WRITE: begin
                wr_ready = !scan_req;
                if (!scan_req && wr_valid) begin
                    mem_addr = {~front_q, wr_addr};
                    mem_we   = 1'b1;
                end
                // frame_end is ignored here, so a swap_req coincident with
                // frame_end waits for the following frame boundary.
                if (swap_req) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                if (frame_end) begin
                    front_d = ~front_q;
                    if (COPY_ON_SWAP) begin
                        state_d = ST_COPY_RD;
                        cnt_d   = '0;
                    end else begin
                        state_d     = ST_WRITE;
                        swap_done_d = 1'b1;
                    end
                end
            end
            ST_COPY_RD: begin
                if (!scan_req) begin
                    mem_addr = {front_q, cnt_q};
                    state_d  = ST_COPY_CAP;
                end
            end
            ST_COPY_CAP: begin
                // Read data for the COPY_RD address arrives now; a scan read
                // issued in this cycle does not disturb it.
                copy_buf_d = mem_rdata;
                state_d    = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                if (!scan_req) begin
                    mem_addr  = {~front_q, cnt_q};
                    mem_we    = 1'b1;
                    mem_wdata = copy_buf_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_WRITE;
                        swap_done_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_COPY_RD;
                    end
                end
            end
            default: begin
                state_d = ST_WRITE;
            end
        endcase

        // No RAM writes or writer handshakes while reset is held.
        if (reset) begin
            mem_we   = 1'b0;
            wr_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WRITE;
            front_q      <= 1'b0;
            cnt_q        <= '0;
            copy_buf_q   <= '0;
            scan_valid_q <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            cnt_q        <= cnt_d;
            copy_buf_q   <= copy_buf_d;
            scan_valid_q <= scan_req;
            swap_done_q  <= swap_done_d;
        end
    end

    assign scan_data  = mem_rdata;
    assign scan_valid = scan_valid_q;
    assign swap_done  = swap_done_q;
    assign front      = front_q;
    assign busy       = (state_q != ST_WRITE);

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for fb_bank_arbiter. Two instances share all stimulus: dut0 with
// COPY_ON_SWAP=0 and dut1 with COPY_ON_SWAP=1, each with its own RAM model.
// ref_mem is the bench's own picture of dut1's RAM contents.
// ---------------------------------------------------------------------------
module tb_fb_bank_arbiter;

    localparam int AW = 12;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          frame_end;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;

    logic [DW-1:0] scan_data_0, scan_data_1;
    logic          scan_valid_0, scan_valid_1;
    logic          wr_ready_0, wr_ready_1;
    logic          swap_done_0, swap_done_1;
    logic          front_0, front_1;
    logic          busy_0, busy_1;
    logic [AW:0]   mem_addr_0, mem_addr_1;
    logic          mem_we_0, mem_we_1;
    logic [DW-1:0] mem_wdata_0, mem_wdata_1;
    logic [DW-1:0] mem_rdata_0, mem_rdata_1;

    fb_bank_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .COPY_ON_SWAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_data(scan_data_0), .scan_valid(scan_valid_0), .frame_end(frame_end),
        .wr_valid(wr_valid), .wr_ready(wr_ready_0), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_done(swap_done_0), .front(front_0), .busy(busy_0),
        .mem_addr(mem_addr_0), .mem_we(mem_we_0), .mem_wdata(mem_wdata_0),
        .mem_rdata(mem_rdata_0)
    );

    fb_bank_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .COPY_ON_SWAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_data(scan_data_1), .scan_valid(scan_valid_1), .frame_end(frame_end),
        .wr_valid(wr_valid), .wr_ready(wr_ready_1), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_done(swap_done_1), .front(front_1), .busy(busy_1),
        .mem_addr(mem_addr_1), .mem_we(mem_we_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1)
    );

    // Synchronous single-port RAM models, read data one cycle after address.
    logic [DW-1:0] ram0 [0:8191];
    logic [DW-1:0] ram1 [0:8191];
    logic [DW-1:0] ref_mem [0:8191];

    always @(posedge clk) begin
        if (mem_we_0) ram0[mem_addr_0] <= mem_wdata_0;
        mem_rdata_0 <= ram0[mem_addr_0];
        if (mem_we_1) ram1[mem_addr_1] <= mem_wdata_1;
        mem_rdata_1 <= ram1[mem_addr_1];
    end

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q[$];
    bit            sv_exp;
    logic          exp_front;
    bit            cov [0:4095];
    int            cov_cnt;
    bit            cov_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: sample copy writes, push scan expectations, advance,
    // then check the registered scan outputs.
    task automatic cyc();
        logic [DW-1:0] e;
        #1;
        if (cov_en && mem_we_1 && busy_1 && (mem_addr_1[AW] == ~exp_front)) begin
            if (!cov[mem_addr_1[AW-1:0]]) begin
                cov[mem_addr_1[AW-1:0]] = 1'b1;
                cov_cnt++;
            end
        end
        sv_exp = scan_req;
        if (scan_req) sb_q.push_back(ref_mem[{exp_front, scan_addr}]);
        @(posedge clk);
        #1;
        chk("scan_valid0", scan_valid_0, sv_exp);
        chk("scan_valid1", scan_valid_1, sv_exp);
        if (sv_exp) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("scan_data1", scan_data_1, e);
            end
        end
    endtask

    typedef struct {
        bit          sreq;
        logic [11:0] saddr;
        bit          wv;
        logic [11:0] waddr;
        logic [23:0] wdata;
        bit          e_rdy;
        bit          e_we;
        logic [12:0] e_addr;
    } vec_t;

    vec_t vt [6];

    initial begin
        int n;
        int bad;
        int pulses;

        for (int a = 0; a < 8192; a++) begin
            ram0[a] = '0;
            ram1[a] = '0;
            ref_mem[a] = '0;
        end
        for (int a = 0; a < 4096; a++) cov[a] = 1'b0;
        cov_cnt = 0;
        cov_en = 1'b0;
        exp_front = 1'b0;

        vt[0] = '{0, 12'h000, 1, 12'h000, 24'hFF0000, 1, 1, 13'h1000};
        vt[1] = '{0, 12'h000, 1, 12'hFFF, 24'h00FF00, 1, 1, 13'h1FFF};
        vt[2] = '{0, 12'h000, 0, 12'h000, 24'h000000, 1, 0, 13'h0000};
        vt[3] = '{1, 12'h000, 1, 12'h0AB, 24'h123456, 0, 0, 13'h0000};
        vt[4] = '{0, 12'h000, 1, 12'h0AB, 24'h123456, 1, 1, 13'h10AB};
        vt[5] = '{1, 12'h0AB, 0, 12'h000, 24'h000000, 0, 0, 13'h00AB};

        // Reset values, with a writer already presenting data.
        reset = 1'b1;
        scan_req = 1'b0; scan_addr = '0; frame_end = 1'b0;
        wr_valid = 1'b1; wr_addr = 12'h123; wr_data = 24'h777777; swap_req = 1'b0;
        cyc();
        cyc();
        chk("rst_front", front_1, 0);
        chk("rst_busy", busy_1, 0);
        chk("rst_swap_done", swap_done_1, 0);
        chk("rst_wr_ready", wr_ready_1, 0);
        chk("rst_mem_we0", mem_we_0, 0);
        chk("rst_mem_we1", mem_we_1, 0);
        reset = 1'b0;
        wr_valid = 1'b0;
        cyc();

        // Table-driven write/scan vectors.
        for (int i = 0; i < 6; i++) begin
            scan_req = vt[i].sreq; scan_addr = vt[i].saddr;
            wr_valid = vt[i].wv; wr_addr = vt[i].waddr; wr_data = vt[i].wdata;
            #1;
            chk("vec_wr_ready0", wr_ready_0, vt[i].e_rdy);
            chk("vec_wr_ready1", wr_ready_1, vt[i].e_rdy);
            chk("vec_mem_we1", mem_we_1, vt[i].e_we);
            chk("vec_front", front_1, 0);
            if (vt[i].e_we || vt[i].sreq) chk("vec_mem_addr1", mem_addr_1, vt[i].e_addr);
            if (vt[i].e_we) chk("vec_mem_wdata1", mem_wdata_1, vt[i].wdata);
            if (vt[i].wv && vt[i].e_rdy) ref_mem[{~exp_front, vt[i].waddr}] = vt[i].wdata;
            cyc();
        end

        // Scan holds the slot for 10 cycles; the pending write lands right after.
        wr_valid = 1'b1; wr_addr = 12'h555; wr_data = 24'hABCDEF;
        for (int i = 0; i < 10; i++) begin
            scan_req = 1'b1; scan_addr = 12'(i * 37);
            #1;
            chk("hold_wr_ready", wr_ready_1, 0);
            chk("hold_mem_we", mem_we_1, 0);
            cyc();
        end
        scan_req = 1'b0;
        #1;
        chk("hold_release_we", mem_we_1, 1);
        chk("hold_release_addr", mem_addr_1, 13'h1555);
        ref_mem[13'h1555] = 24'hABCDEF;
        cyc();
        wr_valid = 1'b0;

        // Fill more back-bank pixels so the copy has real data to move.
        for (int i = 0; i < 64; i++) begin
            wr_valid = 1'b1;
            wr_addr = 12'($urandom_range(1, 4094));
            wr_data = 24'($urandom);
            #1;
            chk("fill_we", mem_we_1, 1);
            ref_mem[{1'b1, wr_addr}] = wr_data;
            cyc();
        end
        wr_valid = 1'b0;

        // Swap 1: frame_end 5 cycles after swap_req.
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("swap_wait_busy0", busy_0, 1);
            chk("swap_wait_busy1", busy_1, 1);
            chk("swap_wait_front", front_0, 0);
            cyc();
        end
        frame_end = 1'b1;
        cov_en = 1'b1;
        cyc();
        frame_end = 1'b0;
        exp_front = 1'b1;
        chk("swap1_front0", front_0, 1);
        chk("swap1_front1", front_1, 1);
        chk("swap1_done0", swap_done_0, 1);
        chk("swap1_busy0", busy_0, 0);
        chk("swap1_busy1", busy_1, 1);
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 1) chk("swap1_done0_pulse", swap_done_0, 0);
        end while (!swap_done_1 && n < 20000);
        cov_en = 1'b0;
        chk("copy1_cycles", n, 12288);
        chk("copy1_coverage", cov_cnt, 4096);
        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if (ram1[{1'b0, 12'(a)}] !== ref_mem[{1'b1, 12'(a)}]) bad++;
            ref_mem[{1'b0, 12'(a)}] = ref_mem[{1'b1, 12'(a)}];
        end
        chk("copy1_data", bad, 0);
        cyc();
        chk("copy1_done_pulse", swap_done_1, 0);

        // Scan of pixel 0 now shows what the writer put in the old back bank.
        scan_req = 1'b1; scan_addr = 12'h000;
        cyc();
        chk("swap1_scan0_data", scan_data_0, 24'hFF0000);
        scan_req = 1'b0;
        cyc();

        // Swap 2: copy with scan_req on alternating cycles.
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        exp_front = 1'b0;
        chk("swap2_front1", front_1, 0);
        n = 0;
        do begin
            scan_req = n[0];
            scan_addr = 12'($urandom);
            #1;
            if (scan_req) chk("alt_scan_no_we", mem_we_1, 0);
            cyc();
            n++;
        end while (!swap_done_1 && n < 60000);
        chk("copy2_done", swap_done_1, 1);
        scan_req = 1'b0;
        cyc();
        chk("sb_empty", sb_q.size(), 0);
        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if (ram1[{1'b1, 12'(a)}] !== ref_mem[{1'b0, 12'(a)}]) bad++;
            ref_mem[{1'b1, 12'(a)}] = ref_mem[{1'b0, 12'(a)}];
        end
        chk("copy2_data", bad, 0);

        // Swap 3: reset when the copy counter reaches 0x400.
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        exp_front = 1'b1;
        chk("swap3_front1", front_1, 1);
        for (int i = 0; i < 3 * 1024; i++) cyc();
        chk("swap3_busy_before_rst", busy_1, 1);
        reset = 1'b1;
        wr_valid = 1'b1;
        #1;
        exp_front = 1'b0;
        chk("midrst_front", front_1, 0);
        chk("midrst_busy", busy_1, 0);
        chk("midrst_mem_we", mem_we_1, 0);
        chk("midrst_wr_ready", wr_ready_1, 0);
        wr_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("postrst_wr_ready", wr_ready_1, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (swap_done_1 || swap_done_0) pulses++;
        end
        chk("postrst_no_swap_done", pulses, 0);

        // swap_req together with frame_end: swap waits for the next frame_end.
        swap_req = 1'b1; frame_end = 1'b1;
        cyc();
        swap_req = 1'b0; frame_end = 1'b0;
        chk("coinc_busy", busy_1, 1);
        chk("coinc_front", front_1, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (swap_done_0 || front_0 || front_1) pulses++;
        end
        chk("coinc_no_early_swap", pulses, 0);
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        chk("coinc_front0", front_0, 1);
        chk("coinc_front1", front_1, 1);
        chk("coinc_done0", swap_done_0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_bank_arbiter.md
Name: fb_bank_arbiter

Overview:
- Owns the single-port frame-buffer RAM (two banks of 64x64 pixels, 24-bit RGB) that feeds the LED panel scan.
- Arbitrates between the panel scan reader and a pixel writer. The scan reader has absolute priority because it has hard timing.
- Performs a double-buffer bank swap only at frame boundaries.
- Optionally copies the new front bank into the back bank after a swap, so the writer can apply incremental updates.

Parameters:
- ADDR_BITS, 12, pixel address width per bank ({y[5:0],x[5:0]}).
- DATA_BITS, 24, pixel width ({r,g,b}, 8 bits each).
- COPY_ON_SWAP, 1, 1 = copy front bank into back bank after every swap; 0 = no copy.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- scan_req  in  1  scan read request this cycle
- scan_addr  in  ADDR_BITS  scan pixel address
- scan_data  out  DATA_BITS  read data (mem_rdata passthrough)
- scan_valid  out  1  scan_data valid (scan_req delayed 1 cycle)
- frame_end  in  1  1-cycle pulse from scanner after the last row is latched
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  pixel accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_BITS  writer pixel address (back bank)
- wr_data  in  DATA_BITS  writer pixel
- swap_req  in  1  1-cycle pulse: back bank complete, request swap
- swap_done  out  1  1-cycle pulse: swap taken (and copy finished if enabled)
- front  out  1  bank currently displayed
- busy  out  1  state != WRITE
- mem_addr  out  ADDR_BITS+1  {bank, addr} to RAM, combinational
- mem_we  out  1  RAM write enable, combinational
- mem_wdata  out  DATA_BITS  RAM write data, combinational
- mem_rdata  in  DATA_BITS  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset values: front=0, state=WRITE, scan_valid=0, swap_done=0, busy=0, copy counter=0, copy_buf=0. mem_we=0 and wr_ready=0 while reset is high.
- RAM slot ownership per cycle, in priority order:
  - scan_req=1: scan read, mem_addr={front,scan_addr}, mem_we=0.
  - Otherwise the state machine's slot, per the states below.
- Scan path:
  - Latency is exactly 1: scan_valid(t+1)=scan_req(t), scan_data=mem_rdata.
  - Scan is never stalled, in any state.
- States:
  - WRITE:
    - wr_ready = !scan_req.
    - On accept: mem_addr={~front,wr_addr}, mem_we=1, mem_wdata=wr_data.
    - swap_req -> SWAP_WAIT. A write accepted in the same cycle as swap_req still completes.
  - SWAP_WAIT:
    - wr_ready=0.
    - On frame_end: toggle front, then go to COPY_RD (COPY_ON_SWAP=1, counter cleared) or WRITE with a swap_done pulse (COPY_ON_SWAP=0).
    - swap_req together with frame_end in WRITE does not swap that cycle; the swap waits for the next frame_end.
  - COPY_RD:
    - wr_ready=0.
    - When !scan_req: mem_addr={front,cnt}, read, go to COPY_CAP.
    - When scan_req=1: stay in COPY_RD.
  - COPY_CAP:
    - Capture copy_buf<=mem_rdata unconditionally; this is the cycle after the read.
    - Go to COPY_WR.
  - COPY_WR:
    - When !scan_req: mem_addr={~front,cnt}, mem_we=1, mem_wdata=copy_buf.
    - If cnt==2^ADDR_BITS-1: go to WRITE, pulse swap_done. Otherwise cnt<=cnt+1 and go to COPY_RD.
    - When scan_req=1: hold.
- Ignored inputs:
  - swap_req outside WRITE is ignored; the writer must wait for swap_done.
  - frame_end outside SWAP_WAIT is ignored.
  - wr_valid is ignored whenever wr_ready=0. The writer holds wr_addr/wr_data while wr_valid && !wr_ready.
- Copy counter is ADDR_BITS wide and wraps only at the terminal test. Copy takes ≥3 cycles per word, plus 1 cycle per scan cycle that blocks a RAM slot.
- Reset asserted mid-operation: state returns to WRITE and front=0 immediately. Any copy is aborted, and back-bank contents are undefined.
- busy=1 in SWAP_WAIT and all COPY states.

Test Plan:
- Reset, then no scan traffic. Write addr 0x000 data 0xFF0000 and addr 0xFFF data 0x00FF00 -> mem_we pulses with mem_addr 0x1000 and 0x1FFF; front=0; wr_ready=1 throughout.
- scan_req held high for 10 cycles while wr_valid=1 -> wr_ready=0 and mem_we=0 for all 10 cycles. scan_valid follows scan_req by exactly 1 cycle. The pending write lands in the first cycle after scan_req drops.
- COPY_ON_SWAP=0: swap_req, then frame_end 5 cycles later -> busy=1 for those 5 cycles; front toggles to 1 and swap_done pulses once on the cycle after frame_end. Scan of addr 0x000 then returns 0xFF0000.
- COPY_ON_SWAP=1 with no scan traffic: after the swap, the counter and back-bank writes cover all 4096 addresses. swap_done arrives after 3x4096 cycles. Back bank equals front bank word for word.
- Copy with scan_req high on alternating cycles -> no scan read is lost; scan_valid pattern is exact; copy completes with correct data.
- Assert reset mid-copy (cnt=0x400) -> front=0, busy=0, wr_ready=1 after release, swap_done never pulses. swap_req and frame_end in the same cycle in WRITE -> no swap until the next frame_end.
